// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment readback path: active-low hex glyphs,
// the blank pattern and the digit count of the multiplexed display.
package seg_pkg;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h18;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // True when exactly one active-low digit enable is asserted.
  function automatic logic an_onehot(input logic [NUM_DIGITS-1:0] an);
    return ($countones(~an) == 1);
  endfunction
endpackage

// File: rtl/seg_scan_capture_if.sv
// Multiplexed display bus plus the decoded readback results.
interface seg_scan_capture_if;
  logic [6:0]                       seg_n;
  logic [seg_pkg::NUM_DIGITS-1:0]   an_n;
  logic [4*seg_pkg::NUM_DIGITS-1:0] value;
  logic [seg_pkg::NUM_DIGITS-1:0]   digit_err;
  logic                             valid;
  logic                             frame_done;

  modport master (
    output seg_n, an_n,
    input  value, digit_err, valid, frame_done
  );

  modport slave (
    input  seg_n, an_n,
    output value, digit_err, valid, frame_done
  );
endinterface

// File: rtl/seg_scan_capture_seg_to_hex.sv
// Inverse of the hex-to-segment decoder: maps an active-low glyph back to its
// nibble, flagging any pattern that is not one of the 16 legal glyphs.
module seg_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       err,
  output logic [3:0] nibble
);
  always_comb begin
    err    = 1'b0;
    nibble = 4'h0;
    case (seg_n)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg_scan_capture.sv
// Readback monitor for the multiplexed seven-segment bus: captures each digit
// once it has settled and publishes a 16-bit word per completed scan frame.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_capture_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  logic [6:0]                       seg_q, seg_p;
  logic [NUM_DIGITS-1:0]            an_q, an_p;
  logic [SW-1:0]                    stab_cnt, stab_nxt;
  logic [TW-1:0]                    to_cnt;
  logic                             armed;
  logic [NUM_DIGITS-1:0]            seen;
  logic [NUM_DIGITS-1:0][3:0]       pend_nib;
  logic [NUM_DIGITS-1:0]            pend_err;
  logic [4*NUM_DIGITS-1:0]          value;
  logic [NUM_DIGITS-1:0]            digit_err;
  logic                             valid, frame_done;

  logic                             unstable, capture, frame_fire, timeout;
  logic [NUM_DIGITS-1:0]            cap_vec;
  logic                             dec_err;
  logic [3:0]                       dec_nib;

  seg_to_hex u_dec (
    .seg_n  (seg_q),
    .err    (dec_err),
    .nibble (dec_nib)
  );

  // Anything other than one settled digit (ghosting, blanking, a change)
  // restarts the stability window and re-arms capture.
  always_comb begin
    unstable   = !an_onehot(an_q) || (an_q != an_p) || (seg_q != seg_p);
    stab_nxt   = '0;
    if (!unstable)
      stab_nxt = (stab_cnt == STABLE_MAX) ? STABLE_MAX : stab_cnt + SW'(1);
    capture    = !unstable && armed && (stab_nxt == STABLE_MAX);
    cap_vec    = capture ? ~an_q : '0;
    frame_fire = &seen;
    timeout    = (to_cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= SEG_BLANK;
      seg_p    <= SEG_BLANK;
      an_q     <= '1;
      an_p     <= '1;
      stab_cnt <= '0;
      armed    <= 1'b1;
    end else begin
      seg_q    <= bus.seg_n;
      an_q     <= bus.an_n;
      seg_p    <= seg_q;
      an_p     <= an_q;
      stab_cnt <= stab_nxt;
      if (unstable)     armed <= 1'b1;
      else if (capture) armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_nib <= '0;
      pend_err <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_vec[i]) begin
          pend_nib[i] <= dec_nib;
          pend_err[i] <= dec_err;
        end
      end
    end
  end

  // A capture in the completion/timeout cycle belongs to the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen       <= '0;
      to_cnt     <= '0;
      value      <= '0;
      digit_err  <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_fire;
      if (frame_fire || timeout) seen <= cap_vec;
      else                       seen <= seen | cap_vec;
      if (capture)       to_cnt <= '0;
      else if (!timeout) to_cnt <= to_cnt + TW'(1);
      if (frame_fire) begin
        value     <= pend_nib;
        digit_err <= pend_err;
        valid     <= 1'b1;
      end else if (timeout) begin
        valid     <= 1'b0;
      end
    end
  end

  assign bus.value      = value;
  assign bus.digit_err  = digit_err;
  assign bus.valid      = valid;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: scans frames on the bus and checks the
// published words, error flags, frame pulses and timeout behaviour.
module tb_seg_scan_capture;
  localparam int STAB = 4;
  localparam int TO   = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   fd_cnt = 0;
  int   f0;

  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] frame_exp [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

  always #5 clk = ~clk;

  seg_scan_capture_if bus ();

  seg_scan_capture #(.STABLE_CYCLES(STAB), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the pattern for n rising edges.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.an_n  = an;
    bus.seg_n = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] g0, g1, g2, g3, input int n);
    drive(4'b1110, g0, n);
    drive(4'b1101, g1, n);
    drive(4'b1011, g2, n);
    drive(4'b0111, g3, n);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.an_n  = 4'hF;
    bus.seg_n = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_value", 32'(bus.value), 32'h0);
    chk("rst_err", 32'(bus.digit_err), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: 5,3,2,1 on digits 0..3
    f0 = fd_cnt;
    scan(7'h12, 7'h30, 7'h24, 7'h79, 8);
    drive(4'hF, 7'h7F, 2);
    chk("t1_fd", 32'(fd_cnt - f0), 32'd1);
    chk("t1_value", 32'(bus.value), 32'h1235);
    chk("t1_err", 32'(bus.digit_err), 32'h0);
    chk("t1_valid", 32'(bus.valid), 32'h1);

    // All sixteen glyphs across four frames
    for (int f = 0; f < 4; f++) begin
      f0 = fd_cnt;
      scan(glyph[4*f], glyph[4*f+1], glyph[4*f+2], glyph[4*f+3], 8);
      drive(4'hF, 7'h7F, 2);
      chk("t2_fd", 32'(fd_cnt - f0), 32'd1);
      chk("t2_value", 32'(bus.value), 32'(frame_exp[f]));
    end

    // Blank pattern on digit 2 is an illegal glyph
    scan(7'h19, 7'h12, 7'h7F, 7'h78, 8);
    drive(4'hF, 7'h7F, 2);
    chk("t3_value", 32'(bus.value), 32'h7054);
    chk("t3_err", 32'(bus.digit_err), 32'h4);
    chk("t3_valid", 32'(bus.valid), 32'h1);

    // Short digit and ghosting never complete a frame
    f0 = fd_cnt;
    drive(4'b1110, 7'h18, 8);
    drive(4'b1101, 7'h00, 8);
    drive(4'b1011, 7'h08, 8);
    drive(4'b0111, 7'h03, STAB - 1);
    drive(4'hF, 7'h7F, 4);
    drive(4'b1100, 7'h79, 12);
    drive(4'hF, 7'h7F, 2);
    chk("t4_nofd", 32'(fd_cnt - f0), 32'd0);
    chk("t4_hold", 32'(bus.value), 32'h7054);
    scan(7'h18, 7'h00, 7'h08, 7'h03, 8);
    chk("t4_fd", 32'(fd_cnt - f0), 32'd1);
    chk("t4_value", 32'(bus.value), 32'hBA89);

    // 50-cycle hold: one capture at edge 6, so valid falls at edge 38
    f0 = fd_cnt;
    drive(4'b1110, 7'h02, 37);
    chk("t5_valid_pre", 32'(bus.valid), 32'h1);
    drive(4'b1110, 7'h02, 1);
    chk("t5_valid_to", 32'(bus.valid), 32'h0);
    drive(4'b1110, 7'h02, 12);
    drive(4'hF, 7'h7F, 10);
    chk("t5_valid_idle", 32'(bus.valid), 32'h0);
    chk("t5_hold", 32'(bus.value), 32'hBA89);
    chk("t5_nofd", 32'(fd_cnt - f0), 32'd0);

    // Reset after three digits discards the partial frame
    drive(4'b1110, 7'h79, 8);
    drive(4'b1101, 7'h24, 8);
    drive(4'b1011, 7'h30, 8);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_value", 32'(bus.value), 32'h0);
    chk("t6_rst_err", 32'(bus.digit_err), 32'h0);
    chk("t6_rst_valid", 32'(bus.valid), 32'h0);
    chk("t6_rst_fd", 32'(bus.frame_done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = fd_cnt;
    drive(4'b0111, 7'h19, 8);
    drive(4'hF, 7'h7F, 4);
    chk("t6_nofd", 32'(fd_cnt - f0), 32'd0);
    chk("t6_novalid", 32'(bus.valid), 32'h0);
    scan(7'h79, 7'h24, 7'h30, 7'h19, 8);
    drive(4'hF, 7'h7F, 2);
    chk("t6_fd", 32'(fd_cnt - f0), 32'd1);
    chk("t6_value", 32'(bus.value), 32'h4321);
    chk("t6_err", 32'(bus.digit_err), 32'h0);
    chk("t6_valid", 32'(bus.valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
